// File: rtl/atm_session_fsm.sv
// atm_session_fsm: ATM session sequencer with PIN lockout, inactivity timeout and session-end pulse
module atm_session_fsm #(
  parameter int MAX_PIN_TRIES  = 3,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int LOCK_CYCLES    = 100000000,
  parameter int TIMER_W        = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       usr_valid,
  input  logic [1:0] usr_sel,
  input  logic       status_valid,
  input  logic [3:0] status_code,
  output logic [3:0] current_state,
  output logic [3:0] input_style,
  output logic [3:0] display_mode,
  output logic [3:0] pin_fail_cnt,
  output logic       locked,
  output logic       timeout_pulse,
  output logic       session_end
);
  typedef enum logic [3:0] {
    IDLE, ACC_NUM, PIN, MENU, BAL, CONV_SRC, CONV_AMT, CONV_DST,
    WD_CUR, WD_AMT, XF_ACC, XF_CUR, XF_AMT, ERROR, SUCCESS, LOCKED
  } state_t;
  localparam logic [3:0] ACC_FOUND = 4'd1, ACC_NOT_FOUND = 4'd2, PIN_CORRECT = 4'd3, PIN_INCORRECT = 4'd4;
  localparam logic [3:0] AMT_VALID = 4'd5, AMT_INVALID = 4'd6, EXIT = 4'd7, INPUT_COMPLETE = 4'd8;
  localparam logic [3:0] MAX_TRIES = 4'(MAX_PIN_TRIES);
  state_t state_q, state_d, ev_d, menu_sel;
  logic [TIMER_W-1:0] t_q, t_d;
  logic [3:0] fail_q, fail_d, fail_inc;
  logic any_v, tmo, lk_done, to_d, se_d;
  assign fail_inc = fail_q == MAX_TRIES ? fail_q : fail_q + 4'd1;
  assign menu_sel = usr_sel == 2'd0 ? BAL : usr_sel == 2'd1 ? CONV_SRC : usr_sel == 2'd2 ? WD_CUR : XF_ACC;
  // Event-driven next state; status strobes take precedence over user strobes
  always_comb begin
    ev_d = state_q;
    if (status_valid) begin
      case (state_q)
        ACC_NUM:  ev_d = status_code == ACC_FOUND ? PIN : status_code == ACC_NOT_FOUND ? IDLE : state_q;
        PIN:      ev_d = status_code == PIN_CORRECT ? MENU :
                         (status_code == PIN_INCORRECT && fail_inc == MAX_TRIES) ? LOCKED : state_q;
        MENU:     ev_d = status_code == EXIT ? IDLE : state_q;
        CONV_SRC: ev_d = status_code == INPUT_COMPLETE ? CONV_AMT : state_q;
        CONV_AMT: ev_d = status_code == AMT_VALID ? CONV_DST : status_code == AMT_INVALID ? ERROR : state_q;
        CONV_DST: ev_d = status_code == INPUT_COMPLETE ? SUCCESS : state_q;
        WD_CUR:   ev_d = status_code == INPUT_COMPLETE ? WD_AMT : state_q;
        WD_AMT:   ev_d = status_code == AMT_VALID ? SUCCESS : status_code == AMT_INVALID ? ERROR : state_q;
        XF_ACC:   ev_d = status_code == ACC_FOUND ? XF_CUR : status_code == ACC_NOT_FOUND ? ERROR : state_q;
        XF_CUR:   ev_d = status_code == INPUT_COMPLETE ? XF_AMT : state_q;
        XF_AMT:   ev_d = status_code == AMT_VALID ? SUCCESS : status_code == AMT_INVALID ? ERROR : state_q;
        default:  ev_d = state_q;
      endcase
      if (status_code == EXIT && state_q inside {[BAL:SUCCESS]}) ev_d = MENU;
    end else if (usr_valid) begin
      ev_d = state_q == IDLE ? ACC_NUM : state_q == MENU ? menu_sel : state_q;
    end
  end
  // One counter serves as inactivity timer and lock timer; it restarts on every state change
  always_comb begin
    any_v   = usr_valid | status_valid;
    tmo     = state_q != IDLE && state_q != LOCKED && !any_v && t_q == TIMER_W'(TIMEOUT_CYCLES - 1);
    lk_done = state_q == LOCKED && t_q == TIMER_W'(LOCK_CYCLES - 1);
    state_d = lk_done ? IDLE : state_q == LOCKED ? LOCKED : tmo ? IDLE : ev_d;
    t_d     = (state_d != state_q || state_q == IDLE || (any_v && state_q != LOCKED)) ? '0 : t_q + TIMER_W'(1);
    fail_d  = state_d == IDLE ? 4'd0 :
              (state_q == PIN && status_valid && status_code == PIN_CORRECT) ? 4'd0 :
              (state_q == PIN && status_valid && status_code == PIN_INCORRECT) ? fail_inc : fail_q;
    to_d    = tmo;
    se_d    = state_d == IDLE && state_q != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      t_q           <= '0;
      fail_q        <= 4'd0;
      timeout_pulse <= 1'b0;
      session_end   <= 1'b0;
    end else begin
      state_q       <= state_d;
      t_q           <= t_d;
      fail_q        <= fail_d;
      timeout_pulse <= to_d;
      session_end   <= se_d;
    end
  end
  always_comb begin
    input_style = 4'd1;
    case (state_q)
      ACC_NUM, XF_ACC:                    input_style = 4'd2;
      PIN:                                input_style = 4'd3;
      MENU:                               input_style = 4'd4;
      CONV_SRC, CONV_DST, WD_CUR, XF_CUR: input_style = 4'd5;
      CONV_AMT, WD_AMT, XF_AMT:           input_style = 4'd6;
      default:                            input_style = 4'd1;
    endcase
  end
  assign display_mode  = state_q == IDLE ? 4'd6 : state_q == LOCKED ? 4'd3 : 4'd4;
  assign current_state = state_q;
  assign pin_fail_cnt  = fail_q;
  assign locked        = state_q == LOCKED;
endmodule

// File: doc/atm_session_fsm.md
Name: atm_session_fsm

Overview:
Parametrised second-generation ATM session controller. Sequences the user through account entry, PIN entry, menu and the balance/convert/withdraw/transfer flows. Adds qualified input strobes, PIN retry counting with timed lockout, an inactivity timeout, and a one-cycle session-end pulse. Sits between the keypad/verification front end and the display/transaction blocks.

Parameters:
MAX_PIN_TRIES, 3, consecutive PIN_INCORRECT results that trigger lockout (1..15).
TIMEOUT_CYCLES, 50000000, idle cycles without a valid input before the session aborts (>=2).
LOCK_CYCLES, 100000000, cycles spent in LOCKED before returning to IDLE (>=1).
TIMER_W, 32, width of the timeout and lock counters; must hold max(TIMEOUT_CYCLES, LOCK_CYCLES).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
usr_valid  in  1  one-cycle strobe qualifying usr_sel.
usr_sel  in  2  key/menu code: 0 BALANCE, 1 CONVERT, 2 WITHDRAW, 3 TRANSFER.
status_valid  in  1  one-cycle strobe qualifying status_code.
status_code  in  4  1 ACC_FOUND, 2 ACC_NOT_FOUND, 3 PIN_CORRECT, 4 PIN_INCORRECT, 5 AMT_VALID, 6 AMT_INVALID, 7 EXIT, 8 INPUT_COMPLETE.
current_state  out  4  state encoding (see Behaviour).
input_style  out  4  1 SINGLE_KEY, 2 ACC_NUMBER, 3 PIN_NUMBER, 4 MENU_SELECTION, 5 CURRENCY_TYPE, 6 CURRENCY_AMOUNT.
display_mode  out  4  4 SCROLLING, 6 CYCLING, 3 STATIC.
pin_fail_cnt  out  4  consecutive PIN failures this session.
locked  out  1  high while in LOCKED.
timeout_pulse  out  1  one-cycle pulse when the inactivity timeout fires.
session_end  out  1  one-cycle pulse on any transition into IDLE from a non-IDLE state.

Behaviour:
- Reset (async assert, sync release): state IDLE, counters 0, pin_fail_cnt 0, both pulses 0. Decoded outputs: input_style 1, display_mode 6, locked 0.
- States: IDLE 0, ACC_NUM 1, PIN 2, MENU 3, BAL 4, CONV_SRC 5, CONV_AMT 6, CONV_DST 7, WD_CUR 8, WD_AMT 9, XF_ACC 10, XF_CUR 11, XF_AMT 12, ERROR 13, SUCCESS 14, LOCKED 15.
- Inputs are acted on only when their valid strobe is high. Inputs with their strobe low are ignored, and the state holds.
- Transitions take effect at the clock edge after the strobe (1-cycle latency).
- input_style and display_mode are pure decodes of the state register.
  - IDLE: 1/6. ACC_NUM and XF_ACC: 2/4. PIN: 3/4. MENU: 4/4.
  - CONV_SRC, CONV_DST, WD_CUR, XF_CUR: 5/4. CONV_AMT, WD_AMT, XF_AMT: 6/4.
  - BAL, ERROR, SUCCESS: 1/4. LOCKED: 1/3.
- Transitions:
  - IDLE: usr_valid -> ACC_NUM.
  - ACC_NUM: ACC_FOUND -> PIN; ACC_NOT_FOUND -> IDLE.
  - PIN: PIN_CORRECT -> MENU, with pin_fail_cnt cleared. PIN_INCORRECT increments pin_fail_cnt. If the new count equals MAX_PIN_TRIES -> LOCKED; otherwise stay in PIN.
  - MENU: usr_valid with usr_sel 0/1/2/3 -> BAL/CONV_SRC/WD_CUR/XF_ACC. EXIT -> IDLE.
  - BAL: EXIT -> MENU.
  - CONV_SRC: INPUT_COMPLETE -> CONV_AMT.
  - CONV_AMT: AMT_VALID -> CONV_DST; AMT_INVALID -> ERROR.
  - CONV_DST: INPUT_COMPLETE -> SUCCESS.
  - WD_CUR: INPUT_COMPLETE -> WD_AMT.
  - WD_AMT: AMT_VALID -> SUCCESS; AMT_INVALID -> ERROR.
  - XF_ACC: ACC_FOUND -> XF_CUR; ACC_NOT_FOUND -> ERROR.
  - XF_CUR: INPUT_COMPLETE -> XF_AMT.
  - XF_AMT: AMT_VALID -> SUCCESS; AMT_INVALID -> ERROR.
  - EXIT in every state from BAL through SUCCESS -> MENU.
  - Unlisted codes are ignored.
- If usr_valid and status_valid arrive in the same cycle, status_valid wins. usr_valid is consumed only in IDLE and in MENU.
- Inactivity timer runs in every state except IDLE and LOCKED.
  - It clears on any usr_valid or status_valid, and on every state change.
  - It fires when it reaches TIMEOUT_CYCLES-1: next state IDLE, timeout_pulse=1, session_end=1.
  - If a valid input arrives in the same cycle the timer reaches terminal count, the input wins and the timer clears.
- LOCKED:
  - All inputs ignored; lock counter runs from 0.
  - At LOCK_CYCLES-1 -> IDLE, with pin_fail_cnt cleared and session_end=1.
  - timeout_pulse is never asserted from LOCKED.
- pin_fail_cnt clears on entry to IDLE and on PIN_CORRECT. It saturates at MAX_PIN_TRIES.
- Illegal or unreachable state values recover to IDLE on the next edge.
- Reset mid-session returns immediately to IDLE and clears all counters. session_end is not pulsed.

Test Plan:
Use MAX_PIN_TRIES=3, TIMEOUT_CYCLES=16, LOCK_CYCLES=8.
1. Happy withdraw: usr_valid; ACC_FOUND; PIN_CORRECT; usr_sel=2; INPUT_COMPLETE; AMT_VALID -> states 1,2,3,8,9,14. After EXIT -> state 3, input_style 4.
2. Lockout: three PIN_INCORRECT in PIN -> pin_fail_cnt 1,2,3, state 15, locked=1. After 8 cycles -> state 0, session_end pulse, pin_fail_cnt 0.
3. Timeout: in MENU with no strobes for 16 cycles -> timeout_pulse and session_end high for exactly one cycle, state 0. A strobe at cycle 15 instead keeps MENU.
4. Priority: in MENU, usr_valid with usr_sel=3 together with status EXIT -> state 0, not 10.
5. Ignored inputs: in CONV_SRC, status AMT_VALID or usr_valid -> state stays 5. In LOCKED any strobe -> state stays 15.
6. Async reset in XF_AMT mid-session: rst_n low between edges -> current_state 0 before the next edge, counters 0, no session_end pulse.
